// File: rtl/cpu_pkg.sv
// Shared load/store funct3 codes, host FSM states and the load-data formatter
// used by the memory-access stage.
package cpu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_ACK  = 2'd1,
    H_WAIT = 2'd2
  } host_st_e;

  // One RAM slot request; the address travels separately since its width is a parameter.
  typedef struct packed {
    logic        re;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ram_req_t;

  function automatic logic [31:0] ld_fmt(input logic [31:0] q, input logic [1:0] ofs,
                                         input logic [2:0] code);
    logic [31:0] sh;
    sh = q >> {ofs, 3'b000};
    case (code)
      LDST_B:  return {{24{sh[7]}}, sh[7:0]};
      LDST_H:  return {{16{sh[15]}}, sh[15:0]};
      LDST_BU: return {24'd0, sh[7:0]};
      LDST_HU: return {16'd0, sh[15:0]};
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/ma_stage_if.sv
// Host (debug) data-memory port: level request held until a one-cycle ack.
interface ma_stage_if #(parameter int DMEM_ADR_W = 12) ();
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DMEM_ADR_W-1:0] dmem_adr;
  logic [31:0]           dmem_wdata;
  logic                  dmem_ack;
  logic [31:0]           dmem_rdata;
  logic                  dmem_misalign;

  modport master (output dmem_req, dmem_we, dmem_adr, dmem_wdata,
                  input  dmem_ack, dmem_rdata, dmem_misalign);
  modport slave  (input  dmem_req, dmem_we, dmem_adr, dmem_wdata,
                  output dmem_ack, dmem_rdata, dmem_misalign);
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte enables and a read enable; q holds when re is low.
module dmem_ram #(
  parameter int DMEM_ADR_W = 12
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [3:0]            be,
  input  logic [DMEM_ADR_W-1:0] adr,
  input  logic [31:0]           wdata,
  output logic [31:0]           q
);

  logic [31:0] mem [2**DMEM_ADR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[adr][8*b +: 8] <= wdata[8*b +: 8];
    if (re) q <= mem[adr];
  end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: byte-lane steering, load formatting, WB registers and host port.
// Optional misaligned-access detection is enabled by defining MA_MISALIGN_DET_EN.
module ma_stage
  import cpu_pkg::*;
#(
  parameter int DMEM_ADR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic [31:0] wbk_data_wb2,
  ma_stage_if.slave   host
);

  logic [1:0]            ofs;
  logic [DMEM_ADR_W-1:0] wadr;
  logic                  mis;
  logic                  pipe_ld, pipe_st, host_go;
  logic [3:0]            st_be;
  logic [31:0]           st_wd;
  ram_req_t              req;
  logic [DMEM_ADR_W-1:0] radr;
  logic [31:0]           q;
  host_st_e              hst, hst_nxt;
  logic                  h_rd;

  logic        cmd_ld_wb, mis_wb;
  logic [2:0]  ldst_code_wb;
  logic [1:0]  ofs_wb;
  logic [31:0] rd_data_wb;

  logic unused_adr;
  assign unused_adr = ^rd_data_ma[31:DMEM_ADR_W+2];

  assign ofs  = rd_data_ma[1:0];
  assign wadr = rd_data_ma[DMEM_ADR_W+1:2];

`ifdef MA_MISALIGN_DET_EN
  assign mis = ((ldst_code_ma[1:0] == 2'b01) & ofs[0]) |
               ((ldst_code_ma[1:0] == 2'b10) & (ofs != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign pipe_ld = cmd_ld_ma & ~stall & ~mis;
  assign pipe_st = cmd_st_ma & ~stall & ~mis;
  // Pipeline always owns the slot; host only gets a cycle with no ld/st and no stall.
  assign host_go = (hst == H_IDLE) & host.dmem_req & ~stall & ~cmd_ld_ma & ~cmd_st_ma;

  always_comb begin
    st_wd = st_data_ma;
    st_be = 4'b1111;
    case (ldst_code_ma[1:0])
      2'b00: begin st_wd = {4{st_data_ma[7:0]}};  st_be = 4'b0001 << ofs; end
      2'b01: begin st_wd = {2{st_data_ma[15:0]}}; st_be = ofs[1] ? 4'b1100 : 4'b0011; end
      default: ;
    endcase
  end

  always_comb begin
    req  = '0;
    radr = wadr;
    if (pipe_ld | pipe_st) begin
      req.re    = pipe_ld;
      req.be    = pipe_st ? st_be : 4'b0000;
      req.wdata = st_wd;
    end else if (host_go) begin
      req.re    = ~host.dmem_we;
      req.be    = {4{host.dmem_we}};
      req.wdata = host.dmem_wdata;
      radr      = host.dmem_adr;
    end
  end

  dmem_ram #(.DMEM_ADR_W(DMEM_ADR_W)) u_ram (
    .clk   (clk),
    .re    (req.re),
    .be    (req.be),
    .adr   (radr),
    .wdata (req.wdata),
    .q     (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_adr_wb <= '0; wbk_rd_reg_wb <= 1'b0; cmd_ld_wb <= 1'b0; mis_wb <= 1'b0;
      ldst_code_wb <= '0; ofs_wb <= '0; rd_data_wb <= '0; wbk_data_wb2 <= '0;
    end else if (rst_pipe) begin
      rd_adr_wb <= '0; wbk_rd_reg_wb <= 1'b0; cmd_ld_wb <= 1'b0; mis_wb <= 1'b0;
      ldst_code_wb <= '0; ofs_wb <= '0; rd_data_wb <= '0; wbk_data_wb2 <= '0;
    end else if (!stall) begin
      rd_adr_wb     <= rd_adr_ma;
      wbk_rd_reg_wb <= wbk_rd_reg_ma;
      cmd_ld_wb     <= cmd_ld_ma;
      mis_wb        <= mis;
      ldst_code_wb  <= ldst_code_ma;
      ofs_wb        <= ofs;
      rd_data_wb    <= rd_data_ma;
      wbk_data_wb2  <= wbk_data_wb;
    end
  end

  always_comb begin
    wbk_data_wb = rd_data_wb;
    if (cmd_ld_wb) wbk_data_wb = mis_wb ? 32'd0 : ld_fmt(q, ofs_wb, ldst_code_wb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hst <= H_IDLE;
    else        hst <= hst_nxt;
  end

  always_comb begin
    hst_nxt = hst;
    case (hst)
      H_IDLE:  if (host_go) hst_nxt = H_ACK;
      H_ACK:   hst_nxt = H_WAIT;
      H_WAIT:  if (!host.dmem_req) hst_nxt = H_IDLE;
      default: hst_nxt = H_IDLE;
    endcase
  end

  // Ack and read data are registered out of H_ACK, so rdata is valid alongside ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_rd            <= 1'b0;
      host.dmem_ack   <= 1'b0;
      host.dmem_rdata <= '0;
    end else begin
      if (host_go) h_rd <= ~host.dmem_we;
      host.dmem_ack <= (hst == H_ACK);
      if (hst == H_ACK && h_rd) host.dmem_rdata <= q;
    end
  end

`ifdef MA_MISALIGN_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host.dmem_misalign <= 1'b0;
    else        host.dmem_misalign <= (cmd_ld_ma | cmd_st_ma) & ~stall & mis;
  end
`else
  assign host.dmem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ma_stage.sv
// Scoreboarded bench for ma_stage: load/store lanes, stall, host port, rst_pipe, misalign.
module tb_ma_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, stall, rst_pipe;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic [4:0]  rd_adr_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] wbk_data_wb, wbk_data_wb2;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ma_stage_if #(.DMEM_ADR_W(12)) hif ();

  ma_stage #(.DMEM_ADR_W(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_ld_ma     (cmd_ld_ma),
    .cmd_st_ma     (cmd_st_ma),
    .rd_adr_ma     (rd_adr_ma),
    .rd_data_ma    (rd_data_ma),
    .wbk_rd_reg_ma (wbk_rd_reg_ma),
    .st_data_ma    (st_data_ma),
    .ldst_code_ma  (ldst_code_ma),
    .stall         (stall),
    .rst_pipe      (rst_pipe),
    .rd_adr_wb     (rd_adr_wb),
    .wbk_rd_reg_wb (wbk_rd_reg_wb),
    .wbk_data_wb   (wbk_data_wb),
    .wbk_data_wb2  (wbk_data_wb2),
    .host          (hif.slave)
  );

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic drv_idle;
    cmd_ld_ma = 0; cmd_st_ma = 0; wbk_rd_reg_ma = 0; rd_adr_ma = 0; rd_data_ma = 0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    cmd_st_ma = 1; rd_data_ma = a; st_data_ma = d; ldst_code_ma = c;
    step;
    drv_idle;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] c, input logic [31:0] e,
                    input string nm);
    logic [31:0] x;
    cmd_ld_ma = 1; rd_data_ma = a; ldst_code_ma = c; rd_adr_ma = 5'd7; wbk_rd_reg_ma = 1;
    exp_q.push_back(e);
    step;
    drv_idle;
    x = exp_q.pop_front();
    tot_cnt++;
    if (wbk_data_wb !== x) $display("FAIL %s wb: got %h expected %h", nm, wbk_data_wb, x);
    else pass_cnt++;
    step;
    tot_cnt++;
    if (wbk_data_wb2 !== x) $display("FAIL %s wb2: got %h expected %h", nm, wbk_data_wb2, x);
    else pass_cnt++;
  endtask

  task automatic wait_ack(input string nm);
    for (int i = 0; i < 10 && hif.dmem_ack !== 1'b1; i++) step;
    tot_cnt++;
    if (hif.dmem_ack !== 1'b1) $display("FAIL %s ack timeout: got %b expected 1", nm, hif.dmem_ack);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    drv_idle; stall = 0; rst_pipe = 0; st_data_ma = 0; ldst_code_ma = 0;
    hif.dmem_req = 0; hif.dmem_we = 0; hif.dmem_adr = 0; hif.dmem_wdata = 0;
    rst_n = 0;
    step; step;
    tot_cnt++;
    if ({wbk_data_wb, wbk_data_wb2, hif.dmem_rdata, rd_adr_wb, wbk_rd_reg_wb,
         hif.dmem_ack, hif.dmem_misalign} !== '0)
      $display("FAIL reset: wb=%h wb2=%h rdata=%h rd=%h we=%b ack=%b mis=%b expected all 0",
               wbk_data_wb, wbk_data_wb2, hif.dmem_rdata, rd_adr_wb, wbk_rd_reg_wb,
               hif.dmem_ack, hif.dmem_misalign);
    else pass_cnt++;
    rst_n = 1;
    step;
  endtask

  task automatic test_word;
    st(32'h100, 32'h11223344, LDST_W);
    ld(32'h100, LDST_W, 32'h11223344, "sw_lw");
  endtask

  task automatic test_byte;
    st(32'h200, 32'h01020304, LDST_W);
    st(32'h203, 32'h000000A5, LDST_B);
    ld(32'h203, LDST_B,  32'hFFFFFFA5, "lb");
    ld(32'h203, LDST_BU, 32'h000000A5, "lbu");
    ld(32'h200, LDST_W,  32'hA5020304, "sb_neighbours");
  endtask

  task automatic test_half;
    st(32'h300, 32'h55667788, LDST_W);
    st(32'h302, 32'h00008001, LDST_H);
    ld(32'h302, LDST_H,  32'hFFFF8001, "lh");
    ld(32'h302, LDST_HU, 32'h00008001, "lhu");
    ld(32'h300, LDST_H,  32'h00007788, "lh_low");
    ld(32'h301, LDST_BU, 32'h00000077, "lbu_ofs1");
    ld(32'h300, LDST_W,  32'h80017788, "sh_word");
  endtask

  task automatic test_alu_rst_pipe;
    rd_data_ma = 32'h12345678; rd_adr_ma = 5'd9; wbk_rd_reg_ma = 1;
    step;
    tot_cnt++;
    if (wbk_data_wb !== 32'h12345678 || rd_adr_wb !== 5'd9 || wbk_rd_reg_wb !== 1'b1)
      $display("FAIL alu_pass: got %h/%h/%b expected 12345678/09/1", wbk_data_wb, rd_adr_wb,
               wbk_rd_reg_wb);
    else pass_cnt++;
    step;
    tot_cnt++;
    if (wbk_data_wb2 !== 32'h12345678) $display("FAIL alu_wb2: got %h expected 12345678", wbk_data_wb2);
    else pass_cnt++;
    rst_pipe = 1;
    step;
    rst_pipe = 0; drv_idle;
    tot_cnt++;
    if ({wbk_data_wb, wbk_data_wb2, rd_adr_wb, wbk_rd_reg_wb} !== '0)
      $display("FAIL rst_pipe: wb=%h wb2=%h rd=%h we=%b expected all 0", wbk_data_wb,
               wbk_data_wb2, rd_adr_wb, wbk_rd_reg_wb);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [31:0] x;
    hif.dmem_req = 1; hif.dmem_we = 0; hif.dmem_adr = 12'h040;
    cmd_ld_ma = 1; rd_data_ma = 32'h100; ldst_code_ma = LDST_W; wbk_rd_reg_ma = 1;
    step;
    rd_data_ma = 32'h200; stall = 1;
    for (int i = 0; i < 4; i++) begin
      tot_cnt++;
      if (wbk_data_wb !== 32'h11223344 || hif.dmem_ack !== 1'b0)
        $display("FAIL stall_hold %0d: wb=%h ack=%b expected 11223344/0", i, wbk_data_wb, hif.dmem_ack);
      else pass_cnt++;
      if (i < 3) step;
    end
    stall = 0;
    exp_q.push_back(32'hA5020304);
    step;
    drv_idle;
    x = exp_q.pop_front();
    tot_cnt++;
    if (wbk_data_wb !== x || hif.dmem_ack !== 1'b0)
      $display("FAIL stall_release: wb=%h ack=%b expected %h/0", wbk_data_wb, hif.dmem_ack, x);
    else pass_cnt++;
    wait_ack("stall_host");
    tot_cnt++;
    if (hif.dmem_rdata !== 32'h11223344)
      $display("FAIL host_rdata: got %h expected 11223344", hif.dmem_rdata);
    else pass_cnt++;
    hif.dmem_req = 0;
    step;
  endtask

  task automatic test_host;
    int acks;
    hif.dmem_req = 1; hif.dmem_we = 1; hif.dmem_adr = 12'd5; hif.dmem_wdata = 32'hDEADBEEF;
    wait_ack("host_wr");
    acks = (hif.dmem_ack === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (hif.dmem_ack === 1'b1) acks++;
    end
    tot_cnt++;
    if (acks != 1) $display("FAIL host_single_ack: got %0d acks expected 1", acks);
    else pass_cnt++;
    hif.dmem_req = 0; hif.dmem_we = 0;
    step; step;
    ld(32'h14, LDST_W, 32'hDEADBEEF, "host_wr_lw");
  endtask

  task automatic test_misalign;
    st(32'h100, 32'hFFFFFFFF, LDST_W);
`ifdef MA_MISALIGN_DET_EN
    tot_cnt++;
    if (hif.dmem_misalign !== 1'b1) $display("FAIL misalign_pulse: got %b expected 1", hif.dmem_misalign);
    else pass_cnt++;
    ld(32'h102, LDST_W, 32'h11223344, "misalign_unchanged_dummy");
`else
    tot_cnt++;
    if (hif.dmem_misalign !== 1'b0) $display("FAIL misalign_off: got %b expected 0", hif.dmem_misalign);
    else pass_cnt++;
`endif
  endtask

  task automatic test_misalign_store;
    st(32'h102, 32'hFFFFFFFF, LDST_W);
    tot_cnt++;
`ifdef MA_MISALIGN_DET_EN
    if (hif.dmem_misalign !== 1'b1) $display("FAIL misalign_pulse: got %b expected 1", hif.dmem_misalign);
    else pass_cnt++;
    step;
    tot_cnt++;
    if (hif.dmem_misalign !== 1'b0) $display("FAIL misalign_once: got %b expected 0", hif.dmem_misalign);
    else pass_cnt++;
    ld(32'h100, LDST_W, 32'h11223344, "misalign_mem_kept");
    ld(32'h301, LDST_H, 32'h00000000, "misalign_ld_zero");
`else
    if (hif.dmem_misalign !== 1'b0) $display("FAIL misalign_off: got %b expected 0", hif.dmem_misalign);
    else pass_cnt++;
    ld(32'h100, LDST_W, 32'hFFFFFFFF, "misalign_lowlane");
    tot_cnt++;
    if (hif.dmem_misalign !== 1'b0) $display("FAIL misalign_off2: got %b expected 0", hif.dmem_misalign);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_alu_rst_pipe;
    test_stall;
    test_host;
    test_misalign_store;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
